// File: rtl/noc_link_pkg.sv
// Shared definitions for the NoC link blocks: counter sizing and pipeline limits.
package noc_link_pkg;

    localparam int MAX_NUM_PIPELINE = 8;

    // Bits needed to hold any count from 0 up to and including n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Synchronous flit FIFO with registered read data and wrap-flag pointers;
// the entry type is a parameter so router input buffers can reuse it.
module noc_flit_fifo
    import noc_link_pkg::*;
#(
    parameter type entry_t = logic [7:0],
    parameter int  DEPTH   = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  entry_t                      wr_data,
    input  logic                        pop,
    output entry_t                      rd_data,
    output logic                        full,
    output logic                        empty,
    output logic [cnt_width(DEPTH)-1:0] occupancy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    entry_t           mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Same index with differing wrap flags means the writer is a full lap ahead.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
    assign occupancy = wr_ptr - rd_ptr;
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[IDX_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                rd_data <= mem[rd_ptr[IDX_W-1:0]];
            end
        end
    end

endmodule

// File: rtl/noc_credit_retiming_link.sv
// Router-to-router link that terminates the credit loop locally: flits are buffered,
// credits go upstream as entries drain, and forwarding is gated by downstream credits.
module noc_credit_retiming_link
    import noc_link_pkg::*;
#(
    parameter int FLIT_WIDTH         = 128,
    parameter int DEST_WIDTH         = 4,
    parameter int NUM_PIPELINE       = 2,
    parameter int BUFFER_DEPTH       = 8,
    parameter int DOWNSTREAM_CREDITS = 8
) (
    input  logic                                     clk_noc,
    input  logic                                     rst_n,
    input  logic [FLIT_WIDTH-1:0]                    data_in,
    input  logic [DEST_WIDTH-1:0]                    dest_in,
    input  logic                                     is_tail_in,
    input  logic                                     send_in,
    output logic                                     credit_out,
    output logic [FLIT_WIDTH-1:0]                    data_out,
    output logic [DEST_WIDTH-1:0]                    dest_out,
    output logic                                     is_tail_out,
    output logic                                     send_out,
    input  logic                                     credit_in,
    output logic [cnt_width(BUFFER_DEPTH)-1:0]       fifo_occupancy,
    output logic [cnt_width(DOWNSTREAM_CREDITS)-1:0] credit_count,
    output logic                                     overflow_err,
    output logic                                     credit_err
);

    localparam int CRED_W = cnt_width(DOWNSTREAM_CREDITS);
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(DOWNSTREAM_CREDITS);
    localparam logic [CRED_W-1:0] CRED_ONE = CRED_W'(1);

    typedef struct packed {
        logic [FLIT_WIDTH-1:0] data;
        logic [DEST_WIDTH-1:0] dest;
        logic                  is_tail;
    } flit_t;

    flit_t             in_flit;
    flit_t             head_flit;
    flit_t             out_flit;
    logic              head_valid;
    logic              out_valid;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              credit_ret;
    logic [CRED_W-1:0] credit_q;

    assign in_flit = '{data: data_in, dest: dest_in, is_tail: is_tail_in};
    assign pop     = !fifo_empty && (credit_q != '0);

    // The FIFO's registered read port doubles as forward stage 0.
    noc_flit_fifo #(
        .entry_t (flit_t),
        .DEPTH   (BUFFER_DEPTH)
    ) u_fifo (
        .clk       (clk_noc),
        .rst_n     (rst_n),
        .push      (send_in),
        .wr_data   (in_flit),
        .pop       (pop),
        .rd_data   (head_flit),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .occupancy (fifo_occupancy)
    );

    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            head_valid <= 1'b0;
            credit_out <= 1'b0;
        end else begin
            head_valid <= pop;
            credit_out <= pop;
        end
    end

    if (NUM_PIPELINE == 0) begin : g_fwd_direct
        assign out_flit  = head_flit;
        assign out_valid = head_valid;
    end else begin : g_fwd_pipe
        flit_t                   stage_flit [NUM_PIPELINE];
        logic [NUM_PIPELINE-1:0] stage_valid;

        always_ff @(posedge clk_noc or negedge rst_n) begin
            if (!rst_n) begin
                stage_valid <= '0;
                for (int i = 0; i < NUM_PIPELINE; i++) begin
                    stage_flit[i] <= '0;
                end
            end else begin
                stage_valid[0] <= head_valid;
                stage_flit[0]  <= head_flit;
                for (int i = 1; i < NUM_PIPELINE; i++) begin
                    stage_valid[i] <= stage_valid[i-1];
                    stage_flit[i]  <= stage_flit[i-1];
                end
            end
        end

        assign out_flit  = stage_flit[NUM_PIPELINE-1];
        assign out_valid = stage_valid[NUM_PIPELINE-1];
    end

    if (NUM_PIPELINE == 0) begin : g_cred_direct
        assign credit_ret = credit_in;
    end else begin : g_cred_pipe
        logic [NUM_PIPELINE-1:0] cred_stage;

        always_ff @(posedge clk_noc or negedge rst_n) begin
            if (!rst_n) begin
                cred_stage <= '0;
            end else begin
                cred_stage[0] <= credit_in;
                for (int i = 1; i < NUM_PIPELINE; i++) begin
                    cred_stage[i] <= cred_stage[i-1];
                end
            end
        end

        assign credit_ret = cred_stage[NUM_PIPELINE-1];
    end

    // A pop and a returned credit in the same cycle cancel out.
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            credit_q     <= CRED_MAX;
            credit_err   <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            if (pop && !credit_ret) begin
                credit_q <= credit_q - CRED_ONE;
            end else if (credit_ret && !pop) begin
                if (credit_q == CRED_MAX) begin
                    credit_err <= 1'b1;
                end else begin
                    credit_q <= credit_q + CRED_ONE;
                end
            end
            if (send_in && fifo_full && !pop) begin
                overflow_err <= 1'b1;
            end
        end
    end

    assign credit_count = credit_q;
    assign data_out     = out_flit.data;
    assign dest_out     = out_flit.dest;
    assign is_tail_out  = out_flit.is_tail;
    assign send_out     = out_valid;

endmodule

// File: tb/tb_noc_credit_retiming_link.sv
// Directed scenario bench for the credit retiming link (NUM_PIPELINE=2) plus a
// randomised scoreboard run on a second instance with NUM_PIPELINE=0.
module tb_noc_credit_retiming_link;

    localparam int FW    = 128;
    localparam int DW    = 4;
    localparam int BD    = 8;
    localparam int DC    = 8;
    localparam int OCC_W = $clog2(BD + 1);
    localparam int CR_W  = $clog2(DC + 1);
    localparam int NRAND = 1000;

    logic clk_noc = 1'b0;
    logic rst_n;
    always #5 clk_noc = ~clk_noc;

    logic [FW-1:0]    data_in, data_out;
    logic [DW-1:0]    dest_in, dest_out;
    logic             is_tail_in, is_tail_out, send_in, send_out, credit_in, credit_out;
    logic [OCC_W-1:0] fifo_occupancy;
    logic [CR_W-1:0]  credit_count;
    logic             overflow_err, credit_err;

    logic [FW-1:0]    r_data_in, r_data_out;
    logic [DW-1:0]    r_dest_in, r_dest_out;
    logic             r_is_tail_in, r_is_tail_out, r_send_in, r_send_out, r_credit_in, r_credit_out;
    logic [OCC_W-1:0] r_fifo_occupancy;
    logic [CR_W-1:0]  r_credit_count;
    logic             r_overflow_err, r_credit_err;

    int errors = 0;
    int checks = 0;

    noc_credit_retiming_link #(
        .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .NUM_PIPELINE(2), .BUFFER_DEPTH(BD), .DOWNSTREAM_CREDITS(DC)
    ) dut (
        .clk_noc(clk_noc), .rst_n(rst_n), .data_in(data_in), .dest_in(dest_in),
        .is_tail_in(is_tail_in), .send_in(send_in), .credit_out(credit_out),
        .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out),
        .send_out(send_out), .credit_in(credit_in), .fifo_occupancy(fifo_occupancy),
        .credit_count(credit_count), .overflow_err(overflow_err), .credit_err(credit_err)
    );

    noc_credit_retiming_link #(
        .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .NUM_PIPELINE(0), .BUFFER_DEPTH(BD), .DOWNSTREAM_CREDITS(DC)
    ) dut_np0 (
        .clk_noc(clk_noc), .rst_n(rst_n), .data_in(r_data_in), .dest_in(r_dest_in),
        .is_tail_in(r_is_tail_in), .send_in(r_send_in), .credit_out(r_credit_out),
        .data_out(r_data_out), .dest_out(r_dest_out), .is_tail_out(r_is_tail_out),
        .send_out(r_send_out), .credit_in(r_credit_in), .fifo_occupancy(r_fifo_occupancy),
        .credit_count(r_credit_count), .overflow_err(r_overflow_err), .credit_err(r_credit_err)
    );

    task automatic step();
        @(posedge clk_noc);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        send_in = 1'b0; credit_in = 1'b0; data_in = '0; dest_in = '0; is_tail_in = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (send_out !== 1'b0 || credit_out !== 1'b0 || data_out !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got send=%0b credit=%0b data=%0h expected 0/0/0", send_out, credit_out, data_out);
        end
        do_reset();
        checks++;
        if (credit_count !== CR_W'(DC)) begin
            errors++;
            $display("[TB] FAIL reset_credit_count: got %0d expected %0d", credit_count, DC);
        end
        checks++;
        if (fifo_occupancy !== '0 || overflow_err !== 1'b0 || credit_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: got occ=%0d ovf=%0b cerr=%0b expected 0/0/0", fifo_occupancy, overflow_err, credit_err);
        end
    endtask

    task automatic test_single_flit();
        do_reset();
        send_in = 1'b1; data_in = FW'(8'hA5); dest_in = 4'd3; is_tail_in = 1'b1;
        step();
        send_in = 1'b0; data_in = '0; dest_in = '0; is_tail_in = 1'b0;
        checks++;
        if (fifo_occupancy !== OCC_W'(1) || credit_count !== CR_W'(8)) begin
            errors++;
            $display("[TB] FAIL single_after_push: got occ=%0d cred=%0d expected 1/8", fifo_occupancy, credit_count);
        end
        step();
        checks++;
        if (credit_out !== 1'b1 || credit_count !== CR_W'(7) || fifo_occupancy !== '0) begin
            errors++;
            $display("[TB] FAIL single_after_pop: got cout=%0b cred=%0d occ=%0d expected 1/7/0", credit_out, credit_count, fifo_occupancy);
        end
        step();
        checks++;
        if (send_out !== 1'b0 || credit_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_early: got send=%0b cout=%0b expected 0/0", send_out, credit_out);
        end
        step();
        checks++;
        if (send_out !== 1'b1 || data_out !== FW'(8'hA5) || dest_out !== 4'd3 || is_tail_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_output: got send=%0b data=%0h dest=%0d tail=%0b expected 1/a5/3/1", send_out, data_out, dest_out, is_tail_out);
        end
        step();
        checks++;
        if (send_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_one_cycle: got send=%0b expected 0", send_out);
        end
        credit_in = 1'b1;
        step();
        credit_in = 1'b0;
        step();
        checks++;
        if (credit_count !== CR_W'(7)) begin
            errors++;
            $display("[TB] FAIL single_credit_in_flight: got %0d expected 7", credit_count);
        end
        step();
        checks++;
        if (credit_count !== CR_W'(8)) begin
            errors++;
            $display("[TB] FAIL single_credit_landed: got %0d expected 8", credit_count);
        end
    endtask

    task automatic test_stream_withheld();
        int sent;
        sent = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send_in = 1'b1; data_in = FW'(256 + i);
            step();
            if (send_out === 1'b1) begin
                checks++;
                if (data_out !== FW'(256 + sent)) begin
                    errors++;
                    $display("[TB] FAIL stream_order: got %0h expected %0h", data_out, 256 + sent);
                end
                sent++;
            end
        end
        send_in = 1'b0; data_in = '0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (send_out === 1'b1) begin
                checks++;
                if (data_out !== FW'(256 + sent)) begin
                    errors++;
                    $display("[TB] FAIL stream_order: got %0h expected %0h", data_out, 256 + sent);
                end
                sent++;
            end
        end
        checks++;
        if (sent != 8 || credit_count !== '0 || fifo_occupancy !== OCC_W'(2) || overflow_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stream_held: got sent=%0d cred=%0d occ=%0d ovf=%0b expected 8/0/2/0", sent, credit_count, fifo_occupancy, overflow_err);
        end
        credit_in = 1'b1;
        step();
        credit_in = 1'b0;
        for (int k = 1; k < 6; k++) begin
            checks++;
            if (send_out !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stream_resume_early: got send=1 at +%0d expected 0", k);
            end
            step();
        end
        checks++;
        if (send_out !== 1'b1 || data_out !== FW'(264)) begin
            errors++;
            $display("[TB] FAIL stream_resume: got send=%0b data=%0h expected 1/108", send_out, data_out);
        end
    endtask

    task automatic test_full_fifo();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send_in = 1'b1; data_in = FW'(768 + i);
            step();
        end
        send_in = 1'b0;
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (fifo_occupancy !== OCC_W'(8) || credit_count !== '0 || overflow_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_setup: got occ=%0d cred=%0d ovf=%0b expected 8/0/0", fifo_occupancy, credit_count, overflow_err);
        end
        credit_in = 1'b1;
        step();
        credit_in = 1'b0;
        step();
        step();
        checks++;
        if (credit_count !== CR_W'(1)) begin
            errors++;
            $display("[TB] FAIL full_credit: got %0d expected 1", credit_count);
        end
        send_in = 1'b1; data_in = FW'(12'h3FF);
        step();
        checks++;
        if (fifo_occupancy !== OCC_W'(8) || credit_count !== '0 || overflow_err !== 1'b0 || credit_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_push_pop: got occ=%0d cred=%0d ovf=%0b cout=%0b expected 8/0/0/1", fifo_occupancy, credit_count, overflow_err, credit_out);
        end
        data_in = FW'(12'h3EE);
        step();
        send_in = 1'b0;
        checks++;
        if (overflow_err !== 1'b1 || fifo_occupancy !== OCC_W'(8)) begin
            errors++;
            $display("[TB] FAIL full_drop: got ovf=%0b occ=%0d expected 1/8", overflow_err, fifo_occupancy);
        end
        step();
        step();
        checks++;
        if (overflow_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_sticky: got ovf=%0b expected 1", overflow_err);
        end
    endtask

    task automatic test_credit_balance();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send_in = 1'b1; data_in = FW'(1024 + i);
            step();
        end
        send_in = 1'b0;
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (credit_count !== CR_W'(3) || fifo_occupancy !== '0) begin
            errors++;
            $display("[TB] FAIL balance_setup: got cred=%0d occ=%0d expected 3/0", credit_count, fifo_occupancy);
        end
        credit_in = 1'b1;
        step();
        credit_in = 1'b0; send_in = 1'b1; data_in = FW'(12'h500);
        step();
        send_in = 1'b0;
        step();
        checks++;
        if (credit_count !== CR_W'(3) || credit_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL balance_same_cycle: got cred=%0d cout=%0b expected 3/1", credit_count, credit_out);
        end
        for (int i = 0; i < 5; i++) begin
            credit_in = 1'b1;
            step();
        end
        credit_in = 1'b0;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (credit_count !== CR_W'(8) || credit_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL balance_refill: got cred=%0d cerr=%0b expected 8/0", credit_count, credit_err);
        end
        credit_in = 1'b1;
        step();
        credit_in = 1'b0;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (credit_count !== CR_W'(8) || credit_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL balance_extra_credit: got cred=%0d cerr=%0b expected 8/1", credit_count, credit_err);
        end
    endtask

    task automatic test_reset_midstream();
        int stale;
        stale = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send_in = 1'b1; data_in = FW'(1280 + i);
            step();
        end
        send_in = 1'b0;
        for (int i = 0; i < 10; i++) step();
        for (int i = 0; i < 7; i++) begin
            send_in = 1'b1; data_in = FW'(1536 + i);
            step();
        end
        send_in = 1'b0;
        credit_in = 1'b1;
        step();
        step();
        credit_in = 1'b0;
        step();
        step();
        step();
        checks++;
        if (fifo_occupancy !== OCC_W'(5) || credit_out !== 1'b1 || send_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_setup: got occ=%0d cout=%0b send=%0b expected 5/1/0", fifo_occupancy, credit_out, send_out);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (credit_out !== 1'b0 || send_out !== 1'b0 || fifo_occupancy !== '0 || credit_count !== CR_W'(DC)) begin
            errors++;
            $display("[TB] FAIL midreset_async: got cout=%0b send=%0b occ=%0d cred=%0d expected 0/0/0/8", credit_out, send_out, fifo_occupancy, credit_count);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (send_out !== 1'b0 || credit_out !== 1'b0) stale++;
        end
        checks++;
        if (stale != 0 || credit_count !== CR_W'(DC) || fifo_occupancy !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_after: got stale=%0d cred=%0d occ=%0d expected 0/8/0", stale, credit_count, fifo_occupancy);
        end
    endtask

    task automatic test_random_np0();
        logic [FW+DW:0] exp_q[$];
        logic [FW+DW:0] exp_flit;
        int up_cred, owed, rx, tx, pulses, cyc;
        up_cred = BD; owed = 0; rx = 0; tx = 0; pulses = 0; cyc = 0;
        while ((rx < NRAND || owed > 0) && cyc < 30000) begin
            if (r_credit_out === 1'b1) begin
                up_cred++;
                pulses++;
            end
            if (r_send_out === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL random_unexpected: got data=%0h expected no flit", r_data_out);
                end else begin
                    exp_flit = exp_q.pop_front();
                    if ({r_data_out, r_dest_out, r_is_tail_out} !== exp_flit) begin
                        errors++;
                        $display("[TB] FAIL random_flit %0d: got %0h expected %0h", rx, {r_data_out, r_dest_out, r_is_tail_out}, exp_flit);
                    end
                end
                rx++;
                owed++;
            end
            r_credit_in = 1'b0;
            if (owed > 0 && $urandom_range(0, 99) >= 30) begin
                r_credit_in = 1'b1;
                owed--;
            end
            r_send_in = 1'b0;
            if (tx < NRAND && up_cred > 0 && $urandom_range(0, 99) < 80) begin
                r_data_in    = {$urandom(), $urandom(), $urandom(), $urandom()};
                r_dest_in    = DW'($urandom());
                r_is_tail_in = 1'($urandom());
                exp_q.push_back({r_data_in, r_dest_in, r_is_tail_in});
                r_send_in = 1'b1;
                up_cred--;
                tx++;
            end
            step();
            cyc++;
        end
        r_send_in = 1'b0;
        r_credit_in = 1'b0;
        step();
        step();
        checks++;
        if (rx != NRAND || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL random_delivery: got rx=%0d left=%0d expected %0d/0", rx, exp_q.size(), NRAND);
        end
        checks++;
        if (pulses != NRAND) begin
            errors++;
            $display("[TB] FAIL random_credit_pulses: got %0d expected %0d", pulses, NRAND);
        end
        checks++;
        if (r_credit_count !== CR_W'(DC) || r_fifo_occupancy !== '0 || r_overflow_err !== 1'b0 || r_credit_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL random_final: got cred=%0d occ=%0d ovf=%0b cerr=%0b expected 8/0/0/0", r_credit_count, r_fifo_occupancy, r_overflow_err, r_credit_err);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b0;
        send_in = 1'b0; credit_in = 1'b0; data_in = '0; dest_in = '0; is_tail_in = 1'b0;
        r_send_in = 1'b0; r_credit_in = 1'b0; r_data_in = '0; r_dest_in = '0; r_is_tail_in = 1'b0;
        test_reset();
        test_single_flit();
        test_stream_withheld();
        test_full_fifo();
        test_credit_balance();
        test_reset_midstream();
        test_random_np0();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/noc_credit_retiming_link.md
Name: noc_credit_retiming_link

Overview:
- Parametrised router-to-router link that terminates the credit loop locally, so link length no longer limits throughput.
- Sits between a router output port and the neighbouring router input port, replacing the plain pipeline link.
- Accepts flits into a local FIFO and returns credits upstream as entries drain.
- Forwards flits downstream through NUM_PIPELINE register stages, gated by its own downstream credit counter.

Parameters:
- FLIT_WIDTH, 128, flit payload width.
- DEST_WIDTH, 4, destination field width (tdest+tid).
- NUM_PIPELINE, 2, extra register stages on the forward flit path and on the returning credit path; 0..8.
- BUFFER_DEPTH, 8, local FIFO entries; equals the credits the upstream router is configured with; power of 2, >=2.
- DOWNSTREAM_CREDITS, 8, initial credit count; equals the downstream router FLIT_BUFFER_DEPTH; >=1.

Ports:
- clk_noc  in  1  NoC clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  FLIT_WIDTH  upstream flit data.
- dest_in  in  DEST_WIDTH  upstream flit destination.
- is_tail_in  in  1  upstream tail marker.
- send_in  in  1  upstream flit valid, one flit per cycle.
- credit_out  out  1  one-cycle credit pulse to upstream.
- data_out  out  FLIT_WIDTH  downstream flit data.
- dest_out  out  DEST_WIDTH  downstream destination.
- is_tail_out  out  1  downstream tail marker.
- send_out  out  1  downstream flit valid.
- credit_in  in  1  credit pulse from downstream.
- fifo_occupancy  out  $clog2(BUFFER_DEPTH+1)  current FIFO entry count.
- credit_count  out  $clog2(DOWNSTREAM_CREDITS+1)  current downstream credits.
- overflow_err  out  1  sticky: send_in arrived while FIFO full and no pop that cycle.
- credit_err  out  1  sticky: credit returned while credit_count == DOWNSTREAM_CREDITS.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - All outputs 0 except credit_count = DOWNSTREAM_CREDITS.
  - FIFO emptied; all pipeline stages' valid bits cleared; data regs cleared to 0.
  - Reset mid-operation discards all in-flight flits and credits; errors cleared.
- Push:
  - send_in=1 writes {data,dest,is_tail} at the edge if occupancy < BUFFER_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the flit is dropped, overflow_err is set, and occupancy is unchanged.
- Pop condition (combinational, cycle t): occupancy > 0 and credit_count > 0.
  - No same-cycle bypass: a flit pushed at edge t is poppable from cycle t+1.
- Forward path:
  - Popped flit loads output register stage 0 at edge t, then shifts through NUM_PIPELINE further stages.
  - send_out is asserted for exactly one cycle, in cycle t+1+NUM_PIPELINE.
  - Minimum send_in-to-send_out latency is 2+NUM_PIPELINE cycles.
  - Throughput is one flit/cycle when credits allow.
- Upstream credit: credit_out is high in cycle t+1 for every pop in cycle t (registered). One pulse per pop; never merged.
- Downstream credit:
  - credit_in passes through NUM_PIPELINE registers, then updates credit_count.
  - Pop alone: -1. Returned credit alone: +1. Both in the same cycle: unchanged.
  - Returned credit while count == DOWNSTREAM_CREDITS (and no pop): ignored, credit_err set.
- Wrap-around: FIFO read/write pointers are $clog2(BUFFER_DEPTH)+1 bits with an MSB wrap flag; full/empty derive from the pointers; occupancy is the pointer difference.
- Ordering: strict FIFO order. is_tail is carried unmodified; the link has no packet awareness.
- No combinational path from any input to any output.

Decomposition:
- Package noc_link_pkg:
  - flit_t struct {data, dest, is_tail}, parametrised via the module's localparam widths.
  - Function cnt_width(n) = $clog2(n+1).
  - MAX_NUM_PIPELINE = 8.
- Sub-module noc_flit_fifo: synchronous FIFO of flit_t.
  - Inputs: push, pop. Outputs: full, empty, occupancy.
  - Registered read data; async active-low reset.
  - Reused later for the router input buffers.
- Top level holds the credit counter, the two pipeline chains (generate loops), and the error flags.

Test Plan:
- Single flit, NUM_PIPELINE=2, DOWNSTREAM_CREDITS=8: send_in at cycle 10 with data=0xA5, dest=3, tail=1 -> send_out with the same fields in cycle 14; credit_out in cycle 12; credit_count 8->7 at cycle 11.
- Streaming, credits withheld: push 10 flits back-to-back with no credit_in, DOWNSTREAM_CREDITS=8 -> exactly 8 send_out, credit_count=0, 2 flits held (fifo_occupancy=2), overflow_err=0. One credit_in pulse -> 9th flit exits 1+NUM_PIPELINE+1 cycles after the pipelined credit lands.
- Full FIFO with simultaneous push/pop: occupancy 8, credit_count>0, send_in asserted -> push accepted, occupancy stays 8, overflow_err=0. Same with credit_count=0 -> flit dropped, overflow_err=1 and sticky.
- Simultaneous pop and credit return at credit_count=3 -> credit_count stays 3. Extra credit at credit_count=8 -> stays 8, credit_err=1.
- Reset mid-stream with 5 flits buffered and 2 in the pipeline: rst_n low -> send_out=0 and credit_out=0 immediately (async). After release: credit_count=8, fifo_occupancy=0, no stale flit emitted.
- NUM_PIPELINE=0, 1000 random flits with random 30% credit delay -> scoreboard confirms in-order, lossless delivery; count of credit_out pulses == 1000.
